out_uart_tx: RTL and testbench

Serial output stage downstream of the nic8 core's output register. Captures each byte the core emits on its out strobe into a small FIFO and transmits it as an 8N1 UART frame on a single `tx` line. The core's output is never back-pressured: bytes arriving when the FIFO is full are dropped and flagged.

---
 rtl/out_uart_tx.sv | 162 ++++++++++++++++
 tb/tb_out_uart_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/out_uart_tx.sv
// Serial output stage for the nic8 core: a small byte FIFO that captures the
// core's output strobe, drained by an 8N1 UART transmitter. Never back-pressures;
// pushes into a full FIFO are discarded and flagged in a sticky drop bit.
module out_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          out_strobe,
    input  logic [7:0]                    out_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          dropped,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [BW-1:0]   baud, baud_n;
    logic [2:0]      bit_idx, bit_n;
    logic [7:0]      shift, shift_n;
    logic            tx_n;
    logic            pop;
    logic            push;
    logic [CW-1:0]   count_n;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [7:0]      mem [FIFO_DEPTH];

    // A full FIFO refuses the push even if the transmitter pops this cycle.
    assign push = out_strobe && (count < DEPTH_C);

    // Occupancy update; a simultaneous push and pop cancel out.
    always_comb begin
        count_n = count;
        if (push && !pop) begin
            count_n = count + CW'(1);
        end else if (!push && pop) begin
            count_n = count - CW'(1);
        end
    end

    // Transmitter next-state, pop request and next line level.
    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    baud_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    if (count != '0) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        // The line register follows the state being entered so it changes on the same edge.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    // Transmitter state and registered line outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            tx      <= tx_n;
            busy    <= (state_n != IDLE);
        end
    end

    // FIFO pointers, occupancy and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (out_strobe && !push) begin
                dropped <= 1'b1;
            end
            count <= count_n;
            full  <= (count_n == DEPTH_C);
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= out_data;
        end
    end

endmodule

// File: tb/tb_out_uart_tx.sv
// Directed bench for out_uart_tx: reset, single frame, back-to-back frames,
// FIFO overflow and asynchronous reset in the middle of a frame.
module tb_out_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clk;
    logic       clk_en;
    logic       reset;
    logic       out_strobe;
    logic [7:0] out_data;
    logic       tx;
    logic       busy;
    logic       full;
    logic       dropped;
    logic [2:0] count;

    int total;
    int bad;

    out_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .out_strobe(out_strobe),
        .out_data  (out_data),
        .tx        (tx),
        .busy      (busy),
        .full      (full),
        .dropped   (dropped),
        .count     (count)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Expected line level j cycles (1..FRAME) after a frame's first edge.
    function automatic logic exp_tx(input logic [7:0] b, input int j);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[(j - 1) / CPB];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        total++; if (tx !== 1'b1)      begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (count !== 3'd0)   begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (full !== 1'b0)    begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (dropped !== 1'b0) begin bad++; $display("FAIL reset_dropped got=%b exp=0", dropped); end
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (3) tick();
        total++; if (tx !== 1'b1 || busy !== 1'b0 || count !== 3'd0)
            begin bad++; $display("FAIL idle_after_reset tx=%b busy=%b count=%0d exp 1/0/0", tx, busy, count); end
    endtask

    task automatic test_single_byte();
        out_strobe = 1'b1; out_data = 8'hA5;
        tick();
        out_strobe = 1'b0;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
        total++; if (tx !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL single_pre tx=%b busy=%b exp 1/0", tx, busy); end
        for (int j = 1; j <= int'(FRAME); j++) begin
            tick();
            total++; if (tx !== exp_tx(8'hA5, j))
                begin bad++; $display("FAIL single_tx cyc=%0d got=%b exp=%b", j, tx, exp_tx(8'hA5, j)); end
            total++; if (busy !== 1'b1)
                begin bad++; $display("FAIL single_busy cyc=%0d got=%b exp=1", j, busy); end
        end
        tick();
        total++; if (busy !== 1'b0 || tx !== 1'b1)
            begin bad++; $display("FAIL single_end busy=%b tx=%b exp 0/1", busy, tx); end
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        logic e;
        out_strobe = 1'b1; out_data = 8'h01;
        tick();
        out_data = 8'h02;
        tick();
        out_strobe = 1'b0;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL b2b_count got=%0d exp=1", count); end
        for (int j = 1; j <= 2 * int'(FRAME); j++) begin
            if (j > 1) tick();
            e = (j <= int'(FRAME)) ? exp_tx(8'h01, j) : exp_tx(8'h02, j - int'(FRAME));
            total++; if (tx !== e)
                begin bad++; $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", j, tx, e); end
            total++; if (busy !== 1'b1)
                begin bad++; $display("FAIL b2b_busy cyc=%0d got=%b exp=1", j, busy); end
        end
        tick();
        total++; if (busy !== 1'b0 || tx !== 1'b1)
            begin bad++; $display("FAIL b2b_end busy=%b tx=%b exp 0/1", busy, tx); end
        repeat (2) tick();
    endtask

    task automatic test_overflow();
        logic [2:0] exp_cnt [6];
        logic [5:0] exp_full;
        logic [5:0] exp_drop;
        logic       e;
        logic       eb;
        int         n;
        exp_cnt[0] = 3'd1; exp_cnt[1] = 3'd1; exp_cnt[2] = 3'd2;
        exp_cnt[3] = 3'd3; exp_cnt[4] = 3'd4; exp_cnt[5] = 3'd4;
        exp_full = 6'b110000;
        exp_drop = 6'b100000;
        out_strobe = 1'b1;
        for (int i = 0; i < 6; i++) begin
            out_data = 8'h10 + 8'(i);
            tick();
            total++; if (count !== exp_cnt[i])
                begin bad++; $display("FAIL ovf_count edge=%0d got=%0d exp=%0d", i, count, exp_cnt[i]); end
            total++; if (full !== exp_full[i])
                begin bad++; $display("FAIL ovf_full edge=%0d got=%b exp=%b", i, full, exp_full[i]); end
            total++; if (dropped !== exp_drop[i])
                begin bad++; $display("FAIL ovf_dropped edge=%0d got=%b exp=%b", i, dropped, exp_drop[i]); end
        end
        out_strobe = 1'b0;
        for (int t = 6; t <= 5 * int'(FRAME) + 5; t++) begin
            tick();
            n  = (t - 1) / int'(FRAME);
            e  = (n < 5) ? exp_tx(8'h10 + 8'(n), (t - 1) % int'(FRAME) + 1) : 1'b1;
            eb = (n < 5);
            total++; if (tx !== e)
                begin bad++; $display("FAIL ovf_tx t=%0d got=%b exp=%b", t, tx, e); end
            total++; if (busy !== eb)
                begin bad++; $display("FAIL ovf_busy t=%0d got=%b exp=%b", t, busy, eb); end
        end
        total++; if (count !== 3'd0 || full !== 1'b0 || dropped !== 1'b1)
            begin bad++; $display("FAIL ovf_final count=%0d full=%b dropped=%b exp 0/0/1", count, full, dropped); end
    endtask

    task automatic test_reset_mid_frame();
        out_strobe = 1'b1; out_data = 8'h3C;
        tick();
        out_data = 8'h77;
        tick();
        out_strobe = 1'b0;
        for (int j = 2; j <= 18; j++) tick();
        total++; if (tx !== exp_tx(8'h3C, 18) || busy !== 1'b1 || count !== 3'd1)
            begin bad++; $display("FAIL mid_pre tx=%b busy=%b count=%0d exp %b/1/1", tx, busy, count, exp_tx(8'h3C, 18)); end
        #2 reset = 1'b1;
        #1;
        total++; if (tx !== 1'b1)      begin bad++; $display("FAIL mid_tx got=%b exp=1", tx); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
        total++; if (count !== 3'd0)   begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
        total++; if (dropped !== 1'b0) begin bad++; $display("FAIL mid_dropped got=%b exp=0", dropped); end
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        tick();
        for (int j = 0; j < 6; j++) begin
            total++; if (tx !== 1'b1 || busy !== 1'b0 || count !== 3'd0)
                begin bad++; $display("FAIL mid_idle cyc=%0d tx=%b busy=%b count=%0d exp 1/0/0", j, tx, busy, count); end
            tick();
        end
        out_strobe = 1'b1; out_data = 8'h3C;
        tick();
        out_strobe = 1'b0;
        total++; if (count !== 3'd1 || tx !== 1'b1)
            begin bad++; $display("FAIL mid_push count=%0d tx=%b exp 1/1", count, tx); end
        for (int j = 1; j <= int'(FRAME); j++) begin
            tick();
            total++; if (tx !== exp_tx(8'h3C, j) || busy !== 1'b1)
                begin bad++; $display("FAIL mid_frame cyc=%0d tx=%b busy=%b exp %b/1", j, tx, busy, exp_tx(8'h3C, j)); end
        end
        tick();
        total++; if (busy !== 1'b0 || tx !== 1'b1)
            begin bad++; $display("FAIL mid_end busy=%b tx=%b exp 0/1", busy, tx); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        clk_en     = 1'b0;
        reset      = 1'b0;
        out_strobe = 1'b0;
        out_data   = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
